// File: rtl/jam_search_if.sv
// jam_search_if: start/result handshake and cost ROM port of the job-assignment engine
interface jam_search_if #(
  parameter int N = 8,
  parameter int CW = 7,
  parameter int IW = 3,
  parameter int SW = 10,
  parameter int MCW = 16
);
  logic Start;
  logic [IW-1:0] W;
  logic [IW-1:0] J;
  logic [CW-1:0] Cost;
  logic Busy;
  logic Valid;
  logic [SW-1:0] MinCost;
  logic [MCW-1:0] MatchCount;
  logic [N*IW-1:0] BestPerm;
  modport master (output Start, Cost, input W, J, Busy, Valid, MinCost, MatchCount, BestPerm);
  modport slave (input Start, Cost, output W, J, Busy, Valid, MinCost, MatchCount, BestPerm);
endinterface

// File: rtl/jam_search.sv
// jam_search: exhaustive N x N job assignment search, one permutation per cycle
module jam_search #(
  parameter int N = 8,
  parameter int CW = 7,
  parameter int IW = 3,
  parameter int SW = 10,
  parameter int MCW = 16
) (
  input logic CLK,
  input logic RST,
  jam_search_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, SEARCH, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cost_m [N][N];
  logic [IW-1:0] perm [N];
  logic [IW-1:0] perm_nx [N];
  logic [IW-1:0] swp [N];
  logic [IW-1:0] w, j, k, l;
  logic [N*IW-1:0] perm_flat, s0_perm, best_perm;
  logic [SW-1:0] sum, s0_sum, min_cost;
  logic [MCW-1:0] match_count;
  logic s0_vld, valid, start_ok, last_ld, last_perm;
  assign start_ok = bus.Start && (state == IDLE || state == DONE);
  assign last_ld = w == IW'(N - 1) && j == IW'(N - 1);
  assign bus.W = w;
  assign bus.J = j;
  assign bus.Busy = state == LOAD || state == SEARCH || state == DRAIN;
  assign bus.Valid = valid;
  assign bus.MinCost = min_cost;
  assign bus.MatchCount = match_count;
  assign bus.BestPerm = best_perm;
  // state register
  always_ff @(posedge CLK) state <= RST ? IDLE : state_nx;
  // next-state: load the matrix, sweep all permutations, drain the compare stage
  always_comb begin
    state_nx = start_ok ? LOAD :
               (state == LOAD && last_ld) ? SEARCH :
               (state == SEARCH && last_perm) ? DRAIN :
               (state == DRAIN) ? DONE : state;
  end
  // stage 0: total cost of the current assignment and detection of the final one
  always_comb begin
    sum = '0;
    last_perm = 1'b1;
    perm_flat = '0;
    for (int i = 0; i < N; i++) begin
      sum = sum + SW'(cost_m[i][perm[i]]);
      last_perm = last_perm && perm[i] == IW'(N - 1 - i);
      perm_flat[i*IW +: IW] = perm[i];
    end
  end
  // lexicographic successor: pivot, swap with rightmost larger, reverse the tail
  always_comb begin
    k = '0;
    l = '0;
    for (int i = 0; i < N - 1; i++) if (perm[i] < perm[i+1]) k = IW'(i);
    for (int i = 0; i < N; i++) if (IW'(i) > k && perm[i] > perm[k]) l = IW'(i);
    swp = perm;
    swp[k] = perm[l];
    swp[l] = perm[k];
    for (int i = 0; i < N; i++) perm_nx[i] = IW'(i) > k ? swp[k + IW'(N) - IW'(i)] : swp[i];
  end
  // cost matrix capture while walking the ROM
  always_ff @(posedge CLK) if (state == LOAD) cost_m[w][j] <= bus.Cost;
  // ROM address walk and permutation advance
  always_ff @(posedge CLK) begin
    if (RST || start_ok) begin
      w <= '0;
      j <= '0;
      for (int i = 0; i < N; i++) perm[i] <= IW'(i);
    end else begin
      if (state == LOAD) begin
        j <= j == IW'(N - 1) ? '0 : j + 1'b1;
        w <= last_ld ? '0 : j == IW'(N - 1) ? w + 1'b1 : w;
      end
      if (state == SEARCH && !last_perm) perm <= perm_nx;
    end
  end
  // stage 0 pipeline register
  always_ff @(posedge CLK) begin
    s0_vld <= !RST && state == SEARCH;
    s0_sum <= sum;
    s0_perm <= perm_flat;
  end
  // stage 1: keep the first strict minimum, count ties with saturation
  always_ff @(posedge CLK) begin
    if (RST) begin
      min_cost <= '1;
      match_count <= '0;
      best_perm <= '0;
      valid <= 1'b0;
    end else if (start_ok) begin
      min_cost <= '1;
      match_count <= '0;
      valid <= 1'b0;
    end else begin
      if (s0_vld && s0_sum < min_cost) begin
        min_cost <= s0_sum;
        match_count <= MCW'(1);
        best_perm <= s0_perm;
      end else if (s0_vld && s0_sum == min_cost && match_count != '1) begin
        match_count <= match_count + 1'b1;
      end
      if (state == DRAIN) valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jam_search.sv
// tb_jam_search: random and directed runs against a brute-force assignment model
module tb_jam_search;
  logic CLK = 1'b0;
  logic rst8 = 1'b1, rst3 = 1'b1, rst4 = 1'b1;
  int n_tests = 0, n_fail = 0;
  int mode_a = 0, mode_s = 0;
  int mc [8][8];
  logic [3:0] rom3 [3][3];
  logic [2:0] rom4 [4][4];
  always #5 CLK = ~CLK;
  jam_search_if #(.N(8)) b8a ();
  jam_search_if #(.N(8), .MCW(4)) b8s ();
  jam_search_if #(.N(3), .CW(4), .IW(2), .SW(6)) b3 ();
  jam_search_if #(.N(4), .CW(3), .IW(2), .SW(5), .MCW(2)) b4 ();
  jam_search #(.N(8)) d8a (.CLK(CLK), .RST(rst8), .bus(b8a));
  jam_search #(.N(8), .MCW(4)) d8s (.CLK(CLK), .RST(rst8), .bus(b8s));
  jam_search #(.N(3), .CW(4), .IW(2), .SW(6)) d3 (.CLK(CLK), .RST(rst3), .bus(b3));
  jam_search #(.N(4), .CW(3), .IW(2), .SW(5), .MCW(2)) d4 (.CLK(CLK), .RST(rst4), .bus(b4));
  function automatic logic [6:0] rom8(input int m, input logic [2:0] w, input logic [2:0] j);
    return m == 0 ? 7'd0 : m == 1 ? (j == w ? 7'd10 : 7'd50) : (j == 3'd7 - w ? 7'd1 : 7'd99);
  endfunction
  assign b8a.Cost = rom8(mode_a, b8a.W, b8a.J);
  assign b8s.Cost = rom8(mode_s, b8s.W, b8s.J);
  assign b3.Cost = rom3[b3.W][b3.J];
  assign b4.Cost = rom4[b4.W][b4.J];
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  // enumerate every tuple in lexicographic order and keep only the permutations
  function automatic void model(input int n, input int iw, input int mcmax,
                                output longint mn, output longint cnt, output longint bp);
    int total, x, used, s;
    int d [8];
    bit ok;
    total = 1;
    for (int i = 0; i < n; i++) total *= n;
    mn = 64'd1 << 40;
    cnt = 0;
    bp = 0;
    for (int code = 0; code < total; code++) begin
      x = code;
      for (int i = n - 1; i >= 0; i--) begin
        d[i] = x % n;
        x = x / n;
      end
      used = 0;
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (used[d[i]]) ok = 1'b0;
        used = used | (1 << d[i]);
      end
      if (ok) begin
        s = 0;
        for (int i = 0; i < n; i++) s += mc[i][d[i]];
        if (s < mn) begin
          mn = s;
          cnt = 1;
          bp = 0;
          for (int i = 0; i < n; i++) bp = bp | (longint'(d[i]) << (i * iw));
        end else if (s == mn && cnt < mcmax) begin
          cnt++;
        end
      end
    end
  endfunction
  task automatic run3(input bit poke);
    longint mn, cnt, bp;
    int lat;
    model(3, 2, 65535, mn, cnt, bp);
    b3.Start = 1'b1;
    tick;
    b3.Start = 1'b0;
    chk("busy3", b3.Busy, 1);
    lat = 0;
    if (poke) begin
      for (int q = 0; q < 9; q++) begin
        chk("wj3", {b3.W, b3.J}, (q / 3) * 4 + q % 3);
        b3.Start = q[0];
        tick;
        lat++;
      end
      b3.Start = 1'b0;
    end
    while (!b3.Valid && lat < 100) begin
      tick;
      lat++;
    end
    chk("lat3", lat, 16);
    chk("min3", b3.MinCost, mn);
    chk("cnt3", b3.MatchCount, cnt);
    chk("perm3", b3.BestPerm, bp);
  endtask
  task automatic run4;
    longint mn, cnt, bp;
    int lat;
    model(4, 2, 3, mn, cnt, bp);
    b4.Start = 1'b1;
    tick;
    b4.Start = 1'b0;
    lat = 0;
    while (!b4.Valid && lat < 200) begin
      tick;
      lat++;
    end
    chk("lat4", lat, 41);
    chk("min4", b4.MinCost, mn);
    chk("cnt4", b4.MatchCount, cnt);
    chk("perm4", b4.BestPerm, bp);
  endtask
  task automatic run8(input int ma, input int ms, output int la, output int ls);
    mode_a = ma;
    mode_s = ms;
    b8a.Start = 1'b1;
    b8s.Start = 1'b1;
    tick;
    b8a.Start = 1'b0;
    b8s.Start = 1'b0;
    chk("vdrop8a", b8a.Valid, 0);
    chk("vdrop8s", b8s.Valid, 0);
    chk("busy8a", b8a.Busy, 1);
    la = -1;
    ls = -1;
    for (int c = 1; c <= 41000 && (la < 0 || ls < 0); c++) begin
      tick;
      if (la < 0 && b8a.Valid) la = c;
      if (ls < 0 && b8s.Valid) ls = c;
    end
  endtask
  initial begin
    int la, ls, hi;
    b8a.Start = 1'b0;
    b8s.Start = 1'b0;
    b3.Start = 1'b0;
    b4.Start = 1'b0;
    repeat (3) tick;
    rst8 = 1'b0;
    rst3 = 1'b0;
    rst4 = 1'b0;
    chk("rst_min8", b8a.MinCost, 1023);
    chk("rst_cnt8", b8a.MatchCount, 0);
    chk("rst_perm8", b8a.BestPerm, 0);
    chk("rst_valid8", b8a.Valid, 0);
    chk("rst_busy8", b8a.Busy, 0);
    chk("rst_wj3", {b3.W, b3.J}, 0);
    chk("rst_min3", b3.MinCost, 63);
    rom3 = '{'{4'd4, 4'd2, 4'd8}, '{4'd4, 4'd3, 4'd7}, '{4'd3, 4'd1, 4'd6}};
    for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) mc[w][j] = int'(rom3[w][j]);
    run3(1'b1);
    chk("min3_fixed", b3.MinCost, 12);
    chk("perm3_fixed", b3.BestPerm, 6'h18);
    for (int r = 0; r < 11; r++) begin
      for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) begin
        rom3[w][j] = 4'($urandom_range(0, (r % 2) ? 15 : 2));
        mc[w][j] = int'(rom3[w][j]);
      end
      run3(1'b0);
    end
    for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) begin
      rom4[w][j] = 3'($urandom_range(0, 7));
      mc[w][j] = int'(rom4[w][j]);
    end
    b4.Start = 1'b1;
    tick;
    b4.Start = 1'b0;
    repeat (25) tick;
    chk("busy4_mid", b4.Busy, 1);
    rst4 = 1'b1;
    tick;
    rst4 = 1'b0;
    chk("abort_busy4", b4.Busy, 0);
    chk("abort_valid4", b4.Valid, 0);
    chk("abort_min4", b4.MinCost, 31);
    chk("abort_cnt4", b4.MatchCount, 0);
    repeat (3) tick;
    chk("abort_idle4", b4.Busy, 0);
    run4;
    for (int r = 0; r < 12; r++) begin
      hi = (r % 3 == 0) ? 0 : (r % 3 == 1) ? 1 : 7;
      for (int w = 0; w < 4; w++) for (int j = 0; j < 4; j++) begin
        rom4[w][j] = 3'($urandom_range(0, hi));
        mc[w][j] = int'(rom4[w][j]);
      end
      run4;
    end
    run8(0, 0, la, ls);
    chk("lat8_zero", la, 40385);
    chk("min8_zero", b8a.MinCost, 0);
    chk("cnt8_zero", b8a.MatchCount, 40320);
    chk("perm8_zero", b8a.BestPerm, 24'o76543210);
    chk("lat8s_zero", ls, 40385);
    chk("cnt8s_sat", b8s.MatchCount, 15);
    chk("perm8s_zero", b8s.BestPerm, 24'o76543210);
    run8(2, 1, la, ls);
    chk("lat8_anti", la, 40385);
    chk("min8_anti", b8a.MinCost, 8);
    chk("cnt8_anti", b8a.MatchCount, 1);
    chk("perm8_anti", b8a.BestPerm, 24'o01234567);
    chk("lat8s_diag", ls, 40385);
    chk("min8s_diag", b8s.MinCost, 80);
    chk("cnt8s_diag", b8s.MatchCount, 1);
    chk("perm8s_diag", b8s.BestPerm, 24'o76543210);
    repeat (2) tick;
    chk("hold8_valid", b8a.Valid, 1);
    chk("hold8_busy", b8a.Busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
